// File: rtl/nrd8_pkg.sv
// Shared types and constants for the 8-bit non-restoring divider result stage.
// Tag travels alongside the core; result is what the FIFO stores.
package nrd8_pkg;

    localparam int NRD8_LAT = 7;
    localparam int NRD8_W   = 8;

    typedef struct packed {
        logic              dvd_neg;
        logic              dvs_neg;
        logic              dz;
        logic [NRD8_W-1:0] dividend;
    } nrd8_tag_t;

    typedef struct packed {
        logic [NRD8_W-1:0] quo;
        logic [NRD8_W-1:0] rem;
        logic              dz;
        logic              ovf;
    } nrd8_res_t;

endpackage

// File: rtl/nrd8_fifo_chk.sv
// Checker for the result FIFO: a push must never land in a full FIFO,
// because issue credit is supposed to make that impossible.
module nrd8_fifo_chk #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input logic          clk,
    input logic          rst_n,
    input logic          push,
    input logic [CW-1:0] count
);

    // Flags any push while every entry is occupied.
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count == CW'(DEPTH))));

endmodule

// File: rtl/nrd8_res_fifo.sv
// Synchronous DEPTH-entry result FIFO; head entry and valid are register-driven
// so the consumer sees stable outputs while it stalls.
module nrd8_res_fifo
    import nrd8_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  nrd8_res_t     push_data,
    input  logic          pop,
    output nrd8_res_t     head,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_nxt,
    output logic          valid
);

    nrd8_res_t     mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          valid_r;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_nxt_s = count_r;
        case ({push, pop})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage, pointers, occupancy and the registered non-empty flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= 1'b0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != '0);
        end
    end

    assign head      = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign count_nxt = count_nxt_s;
    assign valid     = valid_r;

    nrd8_fifo_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .count (count_r)
    );

endmodule

// File: rtl/nrd8_post.sv
// Result stage for the pipelined 8-bit divider: delays the issue tag by the core
// latency, applies sign/exception correction and buffers results under credit.
module nrd8_post
    import nrd8_pkg::*;
#(
    parameter int LAT   = NRD8_LAT,
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic              issue_dvd_neg,
    input  logic              issue_dvs_neg,
    input  logic              issue_dvs_zero,
    input  logic [NRD8_W-1:0] issue_dividend,
    input  logic [NRD8_W-1:0] div_quo,
    input  logic [NRD8_W-1:0] div_rem,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NRD8_W-1:0] out_quo,
    output logic [NRD8_W-1:0] out_rem,
    output logic              out_dz,
    output logic              out_ovf
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          v_r   [LAT];
    nrd8_tag_t     tag_r [LAT];
    logic          accept_s;
    logic          push_s;
    logic          pop_s;
    nrd8_tag_t     tail_s;
    nrd8_res_t     res_s;
    nrd8_res_t     head_s;
    logic          sgn_s;
    logic [CW-1:0] inflight_r;
    logic [CW-1:0] inflight_nxt_s;
    logic [CW-1:0] count_s;
    logic [CW-1:0] count_nxt_s;
    logic [CW:0]   credit_sum_s;
    logic          ready_r;

    assign accept_s = issue_valid && ready_r;
    assign push_s   = v_r[LAT-1];
    assign tail_s   = tag_r[LAT-1];
    assign pop_s    = out_valid && out_ready;

    // Tag delay line; it never stalls, so the tail lines up with the core output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) begin
                v_r[i]   <= 1'b0;
                tag_r[i] <= '0;
            end
        end else begin
            v_r[0]   <= accept_s;
            tag_r[0] <= '{dvd_neg:  issue_dvd_neg,
                          dvs_neg:  issue_dvs_neg,
                          dz:       issue_dvs_zero,
                          dividend: issue_dividend};
            for (int i = 1; i < LAT; i++) begin
                v_r[i]   <= v_r[i-1];
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    // Sign correction of the core magnitudes; divide-by-zero overrides everything.
    always_comb begin
        res_s = '0;
        sgn_s = tail_s.dvd_neg ^ tail_s.dvs_neg;
        if (tail_s.dz) begin
            res_s.quo = 8'hFF;
            res_s.rem = tail_s.dividend;
            res_s.dz  = 1'b1;
            res_s.ovf = 1'b0;
        end else begin
            res_s.quo = sgn_s ? (8'h00 - div_quo) : div_quo;
            res_s.rem = tail_s.dvd_neg ? (8'h00 - div_rem) : div_rem;
            res_s.dz  = 1'b0;
            res_s.ovf = !sgn_s && div_quo[7];
        end
    end

    // Operations launched but not yet pushed into the FIFO.
    always_comb begin
        inflight_nxt_s = inflight_r;
        case ({accept_s, push_s})
            2'b10:   inflight_nxt_s = inflight_r + CW'(1);
            2'b01:   inflight_nxt_s = inflight_r - CW'(1);
            default: inflight_nxt_s = inflight_r;
        endcase
    end

    assign credit_sum_s = {1'b0, inflight_nxt_s} + {1'b0, count_nxt_s};

    // Registered credit: a pop only frees a slot for issue from the next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_r <= '0;
            ready_r    <= 1'b1;
        end else begin
            inflight_r <= inflight_nxt_s;
            ready_r    <= (credit_sum_s < (CW+1)'(DEPTH));
        end
    end

    nrd8_res_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push_s),
        .push_data (res_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count_s),
        .count_nxt (count_nxt_s),
        .valid     (out_valid)
    );

    assign issue_ready = ready_r;
    assign out_quo     = head_s.quo;
    assign out_rem     = head_s.rem;
    assign out_dz      = head_s.dz;
    assign out_ovf     = head_s.ovf;

endmodule

// File: doc/nrd8_post.md
Name: nrd8_post

Overview:
- Downstream result stage for the 8-bit pipelined non-restoring divider core.
- Launches an issue-side tag in the same cycle an operand pair enters the core. The tag carries operand signs, a divide-by-zero flag and the original dividend.
- Delays the tag by the core latency and applies sign correction and exception handling to the core's magnitude quotient/remainder.
- Buffers results in a credit-protected FIFO with a valid/ready output handshake, so the core itself never needs to stall.

Parameters:
- LAT, 7, core latency in clock cycles from operand launch to quo/rem valid (7 register banks).
- DEPTH, 8, result FIFO entries; must be >= LAT+1 for full throughput; power of two.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- issue_valid  input  1  operand pair presented to the core this cycle
- issue_ready  output  1  credit available; an issue is accepted when issue_valid && issue_ready
- issue_dvd_neg  input  1  original dividend was negative
- issue_dvs_neg  input  1  original divisor was negative
- issue_dvs_zero  input  1  original divisor was zero
- issue_dividend  input  8  original signed dividend (two's complement)
- div_quo  input  8  core quotient magnitude, unsigned, valid LAT cycles after launch
- div_rem  input  8  core remainder magnitude, unsigned, < divisor magnitude
- out_valid  output  1  result available at FIFO head
- out_ready  input  1  consumer accepts the head this cycle
- out_quo  output  8  signed quotient
- out_rem  output  8  signed remainder
- out_dz  output  1  divide-by-zero flag
- out_ovf  output  1  quotient overflow flag

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - all delay-line valid bits and FIFO pointers/count;
  - out_valid=0, out_quo=0, out_rem=0, out_dz=0, out_ovf=0.
  - issue_ready=1 immediately after release.
- Delay line: LAT-deep shift register of {v, dvd_neg, dvs_neg, dz, dividend[7:0]}.
  - Stage 0 loads v = issue_valid && issue_ready; it shifts every cycle and never stalls.
  - The tail aligns exactly with div_quo/div_rem of the same operation.
- Correction, combinational at the tail, using unsigned magnitudes q and r:
  - If dz: quo=8'hFF, rem=dividend, dz=1, ovf=0.
  - Otherwise:
    - quo = (dvd_neg^dvs_neg) ? -q : q, computed in 8-bit two's complement with wrap;
    - rem = dvd_neg ? -r : r;
    - ovf = !(dvd_neg^dvs_neg) && q[7]. In this case quo wraps to 8'h80.
- FIFO:
  - Push when the tail v=1.
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop is legal; count is unchanged.
  - out_valid = (count!=0). out_* reflect the head entry and hold stable while out_valid && !out_ready.
- Credit:
  - inflight = number of set v bits in the delay line; maintain it as a counter, incremented on accept and decremented on tail push.
  - issue_ready = (inflight + count) < DEPTH.
  - A pop in the current cycle does not raise issue_ready until the next cycle (registered credit; no combinational out_ready->issue_ready path).
  - Overflow of the FIFO is impossible by construction. An assertion must flag a push into a full FIFO.
- Ordering: strictly in issue order; no reordering or dropping.
- Reset mid-operation: in-flight tags are discarded. Core outputs arriving after reset release are ignored because their v bits are 0.
- Widths: inflight and count are $clog2(DEPTH)+1 bits. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.

Decomposition:
- Shared package nrd8_pkg:
  - constants NRD8_LAT=7, NRD8_W=8;
  - tag typedef {dvd_neg, dvs_neg, dz, dividend};
  - result typedef {quo, rem, dz, ovf}.
- One sub-module: nrd8_res_fifo, a synchronous DEPTH x result FIFO with push/pop, count, and async active-low reset.
- Sign correction stays inline in nrd8_post.

Test Plan:
- Issue 100/7 (dvd_neg=0, dvs_neg=0), core returns q=14, r=2 -> 7 cycles later out_quo=8'h0E, out_rem=8'h02, dz=0, ovf=0.
- Issue -100/7 (dvd_neg=1), q=14, r=2 -> out_quo=8'hF2, out_rem=8'hFE. Issue 100/-7 -> out_quo=8'hF2, out_rem=8'h02.
- Issue -128/-1, q=128 (8'h80), r=0 -> out_quo=8'h80, out_ovf=1. Issue -128/1 -> out_quo=8'h80, out_ovf=0.
- Issue 50/0 (dvs_zero=1) -> out_quo=8'hFF, out_rem=8'h32, out_dz=1.
- Hold out_ready=0 and drive issue_valid=1 for 12 cycles:
  - exactly 8 operations are accepted and issue_ready then stays 0;
  - with out_ready=1, results drain in issue order, one per cycle, and credit returns.
- Issue 3 back-to-back operations, assert reset for 1 cycle at cycle 4 -> no out_valid is produced for them, and issue_ready=1 after release.
